ks_ctrl_fsm: RTL and testbench

Parametrised multi-cycle control FSM for the K&S processor. It sequences fetch, decode, execute, memory and halt phases for the full decoded instruction set. It adds configurable RAM wait states, a selectable overflow source, and restart from HALT. It sits between the instruction decoder (`decoded_instruction`, flags) and the datapath/RAM enables.

---
 rtl/ks_ctrl_fsm.sv | 216 +++++++++++++++++++++
 tb/tb_ks_ctrl_fsm.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ks_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : ks_ctrl_fsm
//  Purpose  : Multi-cycle control FSM for the K&S processor. Sequences
//             fetch / decode / execute / memory / halt phases, inserts
//             MEM_WAIT extra cycles per RAM access, selects the overflow
//             source for BOV/BNOV and optionally restarts from HALT.
//  Decoded instruction encoding (4 bits):
//             0 NOP    1 LOAD   2 STORE  3 MOVE   4 ADD    5 SUB
//             6 AND    7 OR     8 BRANCH 9 BZERO 10 BNZERO 11 BNEG
//            12 BNNEG 13 BOV   14 BNOV  15 HALT
//  Revision : 1.0 - initial release
// ============================================================================
module ks_ctrl_fsm #(
  parameter int MEM_WAIT    = 0,
  parameter int OV_SIGNED   = 1,
  parameter int HALT_RESUME = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] decoded_instruction,
  input  logic       zero_op,
  input  logic       neg_op,
  input  logic       unsigned_overflow,
  input  logic       signed_overflow,
  input  logic       resume,
  output logic       branch,
  output logic       pc_enable,
  output logic       ir_enable,
  output logic       write_reg_enable,
  output logic       addr_sel,
  output logic       c_sel,
  output logic [1:0] operation,
  output logic       flags_reg_enable,
  output logic       ram_write_enable,
  output logic       halt,
  output logic       instr_done
);

  // Wait counter width: at least one bit even when no wait states are used.
  localparam int WAIT_W = (MEM_WAIT < 1) ? 1 : $clog2(MEM_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  localparam logic [3:0] I_NOP    = 4'd0;
  localparam logic [3:0] I_LOAD   = 4'd1;
  localparam logic [3:0] I_STORE  = 4'd2;
  localparam logic [3:0] I_MOVE   = 4'd3;
  localparam logic [3:0] I_ADD    = 4'd4;
  localparam logic [3:0] I_SUB    = 4'd5;
  localparam logic [3:0] I_AND    = 4'd6;
  localparam logic [3:0] I_OR     = 4'd7;
  localparam logic [3:0] I_BRANCH = 4'd8;
  localparam logic [3:0] I_BZERO  = 4'd9;
  localparam logic [3:0] I_BNZERO = 4'd10;
  localparam logic [3:0] I_BNEG   = 4'd11;
  localparam logic [3:0] I_BNNEG  = 4'd12;
  localparam logic [3:0] I_BOV    = 4'd13;
  localparam logic [3:0] I_BNOV   = 4'd14;
  localparam logic [3:0] I_HALT   = 4'd15;

  localparam logic [2:0] S_FETCH       = 3'd0;
  localparam logic [2:0] S_DECODE      = 3'd1;
  localparam logic [2:0] S_EXEC_ALU    = 3'd2;
  localparam logic [2:0] S_EXEC_MOVE   = 3'd3;
  localparam logic [2:0] S_MEM_LOAD    = 3'd4;
  localparam logic [2:0] S_MEM_STORE   = 3'd5;
  localparam logic [2:0] S_EXEC_BRANCH = 3'd6;
  localparam logic [2:0] S_HALTED      = 3'd7;

  logic [2:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              halt_seen_q, halt_seen_d;
  logic [2:0]        dispatch;
  logic              last_wait;
  logic              ov;
  logic              taken;
  logic [1:0]        alu_op;

  assign last_wait = (wait_cnt_q == WAIT_LAST);

  // Instruction class -> execute state; unknown codes and NOP retire in DECODE.
  always_comb begin
    dispatch = S_FETCH;
    case (decoded_instruction)
      I_ADD, I_SUB, I_AND, I_OR:        dispatch = S_EXEC_ALU;
      I_MOVE:                           dispatch = S_EXEC_MOVE;
      I_LOAD:                           dispatch = S_MEM_LOAD;
      I_STORE:                          dispatch = S_MEM_STORE;
      I_BRANCH, I_BZERO, I_BNZERO,
      I_BNEG, I_BNNEG, I_BOV, I_BNOV:   dispatch = S_EXEC_BRANCH;
      I_HALT:                           dispatch = S_HALTED;
      default:                          dispatch = S_FETCH;
    endcase
  end

  // Branch condition and ALU opcode, both pure functions of the decode and flags.
  always_comb begin
    ov     = (OV_SIGNED != 0) ? signed_overflow : unsigned_overflow;
    taken  = 1'b0;
    alu_op = 2'b00;
    case (decoded_instruction)
      I_BRANCH: taken = 1'b1;
      I_BZERO:  taken = zero_op;
      I_BNZERO: taken = !zero_op;
      I_BNEG:   taken = neg_op;
      I_BNNEG:  taken = !neg_op;
      I_BOV:    taken = ov;
      I_BNOV:   taken = !ov;
      default:  taken = 1'b0;
    endcase
    case (decoded_instruction)
      I_ADD:   alu_op = 2'b01;
      I_SUB:   alu_op = 2'b10;
      I_AND:   alu_op = 2'b11;
      default: alu_op = 2'b00;
    endcase
  end

  // Next-state logic; the wait counter restarts at zero on every state change.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = '0;
    halt_seen_d = (state_q == S_HALTED);
    case (state_q)
      S_FETCH: begin
        if (last_wait) state_d = S_DECODE;
        else           wait_cnt_d = wait_cnt_q + WAIT_ONE;
      end
      S_DECODE:      state_d = dispatch;
      S_EXEC_ALU,
      S_EXEC_MOVE,
      S_EXEC_BRANCH: state_d = S_FETCH;
      S_MEM_LOAD,
      S_MEM_STORE: begin
        if (last_wait) state_d = S_FETCH;
        else           wait_cnt_d = wait_cnt_q + WAIT_ONE;
      end
      S_HALTED: begin
        if ((HALT_RESUME != 0) && resume) state_d = S_FETCH;
      end
      default:       state_d = S_FETCH;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      wait_cnt_q  <= '0;
      halt_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      halt_seen_q <= halt_seen_d;
    end
  end

  // Output decode; everything is forced low while reset is held so no
  // strobe can leak out of an interrupted instruction.
  always_comb begin
    branch           = 1'b0;
    pc_enable        = 1'b0;
    ir_enable        = 1'b0;
    write_reg_enable = 1'b0;
    addr_sel         = 1'b0;
    c_sel            = 1'b0;
    operation        = 2'b00;
    flags_reg_enable = 1'b0;
    ram_write_enable = 1'b0;
    halt             = 1'b0;
    instr_done       = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          ir_enable = last_wait;
          pc_enable = last_wait;
        end
        S_DECODE: instr_done = (dispatch == S_FETCH);
        S_EXEC_ALU: begin
          write_reg_enable = 1'b1;
          flags_reg_enable = 1'b1;
          operation        = alu_op;
          instr_done       = 1'b1;
        end
        S_EXEC_MOVE: begin
          write_reg_enable = 1'b1;
          instr_done       = 1'b1;
        end
        S_MEM_LOAD: begin
          addr_sel         = 1'b1;
          write_reg_enable = last_wait;
          c_sel            = last_wait;
          instr_done       = last_wait;
        end
        S_MEM_STORE: begin
          addr_sel         = 1'b1;
          ram_write_enable = last_wait;
          instr_done       = last_wait;
        end
        S_EXEC_BRANCH: begin
          branch     = taken;
          pc_enable  = taken;
          instr_done = 1'b1;
        end
        S_HALTED: begin
          halt       = 1'b1;
          instr_done = !halt_seen_q;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ks_ctrl_fsm.sv
`default_nettype none
// Bench for ks_ctrl_fsm: three instances with different parameter sets,
// hand-written sequences, an instruction table and a randomized run
// against a cycle-index reference model.
module tb_ks_ctrl_fsm;

  localparam int NI = 3;

  localparam logic [3:0] I_NOP = 4'd0,  I_LOAD = 4'd1,  I_STORE = 4'd2,  I_MOVE = 4'd3;
  localparam logic [3:0] I_ADD = 4'd4,  I_SUB = 4'd5,   I_AND = 4'd6,    I_OR = 4'd7;
  localparam logic [3:0] I_BRANCH = 4'd8, I_BZERO = 4'd9, I_BNZERO = 4'd10, I_BNEG = 4'd11;
  localparam logic [3:0] I_BNNEG = 4'd12, I_BOV = 4'd13, I_BNOV = 4'd14, I_HALT = 4'd15;

  // Packed output vector: {branch, pc, ir, wre, addr_sel, c_sel, op[1:0], fre, ram_we, halt, done}
  localparam logic [11:0] V_BR = 12'h800, V_PC = 12'h400, V_IR = 12'h200, V_WR = 12'h100;
  localparam logic [11:0] V_AS = 12'h080, V_CS = 12'h040, V_OP1 = 12'h010, V_OP2 = 12'h020;
  localparam logic [11:0] V_OP3 = 12'h030, V_FR = 12'h008, V_RW = 12'h004, V_HT = 12'h002;
  localparam logic [11:0] V_DN = 12'h001, V_Z = 12'h000;

  logic       clk = 1'b0;
  logic       rst_n [NI];
  logic [3:0] di [NI];
  logic       zf [NI], nf [NI], uf [NI], sf [NI], rs [NI];
  wire [11:0] ov0, ov1, ov2;

  always #5 clk = ~clk;

  ks_ctrl_fsm #(.MEM_WAIT(0), .OV_SIGNED(1), .HALT_RESUME(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .decoded_instruction(di[0]), .zero_op(zf[0]), .neg_op(nf[0]),
    .unsigned_overflow(uf[0]), .signed_overflow(sf[0]), .resume(rs[0]),
    .branch(ov0[11]), .pc_enable(ov0[10]), .ir_enable(ov0[9]), .write_reg_enable(ov0[8]),
    .addr_sel(ov0[7]), .c_sel(ov0[6]), .operation(ov0[5:4]), .flags_reg_enable(ov0[3]),
    .ram_write_enable(ov0[2]), .halt(ov0[1]), .instr_done(ov0[0]));

  ks_ctrl_fsm #(.MEM_WAIT(2), .OV_SIGNED(0), .HALT_RESUME(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .decoded_instruction(di[1]), .zero_op(zf[1]), .neg_op(nf[1]),
    .unsigned_overflow(uf[1]), .signed_overflow(sf[1]), .resume(rs[1]),
    .branch(ov1[11]), .pc_enable(ov1[10]), .ir_enable(ov1[9]), .write_reg_enable(ov1[8]),
    .addr_sel(ov1[7]), .c_sel(ov1[6]), .operation(ov1[5:4]), .flags_reg_enable(ov1[3]),
    .ram_write_enable(ov1[2]), .halt(ov1[1]), .instr_done(ov1[0]));

  ks_ctrl_fsm #(.MEM_WAIT(3), .OV_SIGNED(1), .HALT_RESUME(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n[2]), .decoded_instruction(di[2]), .zero_op(zf[2]), .neg_op(nf[2]),
    .unsigned_overflow(uf[2]), .signed_overflow(sf[2]), .resume(rs[2]),
    .branch(ov2[11]), .pc_enable(ov2[10]), .ir_enable(ov2[9]), .write_reg_enable(ov2[8]),
    .addr_sel(ov2[7]), .c_sel(ov2[6]), .operation(ov2[5:4]), .flags_reg_enable(ov2[3]),
    .ram_write_enable(ov2[2]), .halt(ov2[1]), .instr_done(ov2[0]));

  function automatic logic [11:0] outs(int i);
    case (i)
      0:       return ov0;
      1:       return ov1;
      default: return ov2;
    endcase
  endfunction

  function automatic int w_of(int i);
    case (i) 0: return 0; 1: return 2; default: return 3; endcase
  endfunction
  function automatic bit ovs_of(int i); return (i != 1); endfunction
  function automatic bit hr_of(int i);  return (i != 1); endfunction

  int checks = 0;
  int failures = 0;

  task automatic check(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Start a new cycle: inputs are driven 1 time unit after the rising edge.
  task automatic nc();
    @(posedge clk);
    #1;
  endtask

  // Sample well before the next rising edge.
  task automatic ck(int i, string nm, logic [11:0] e);
    #3;
    check(nm, int'(outs(i)), int'(e));
  endtask

  task automatic set_in(int i, logic [3:0] ins, logic z, logic n, logic u, logic s);
    di[i] = ins; zf[i] = z; nf[i] = n; uf[i] = u; sf[i] = s; rs[i] = 1'b0;
  endtask

  // Two reset cycles (outputs must be zero), then release at the start of cycle 1.
  task automatic reset_inst(int i, string nm);
    nc(); rst_n[i] = 1'b0; ck(i, nm, V_Z);
    nc();                  ck(i, nm, V_Z);
    nc(); rst_n[i] = 1'b1;
  endtask

  task automatic run_seq(int i, string nm, bit lead, logic [11:0] e [$]);
    foreach (e[k]) begin
      if (k > 0 || lead) nc();
      ck(i, $sformatf("%s[%0d]", nm, k), e[k]);
    end
  endtask

  // ---------------- reference model (cycle index within an instruction) -------
  int mk [NI];
  bit mh [NI], mhe [NI];

  task automatic model_step(int i, output logic [11:0] e);
    int w, j;
    logic [3:0] op;
    bit ov, tk;
    w = w_of(i); e = V_Z; op = di[i];
    if (!rst_n[i]) begin
      mk[i] = 0; mh[i] = 0; mhe[i] = 0;
      return;
    end
    if (mh[i]) begin
      e = V_HT | (mhe[i] ? V_DN : V_Z);
      mhe[i] = 0;
      if (hr_of(i) && rs[i]) begin mh[i] = 0; mk[i] = 0; end
      return;
    end
    if (mk[i] <= w) begin
      if (mk[i] == w) e = V_IR | V_PC;
      mk[i]++;
      return;
    end
    if (mk[i] == w + 1) begin
      mk[i]++;
      if (op == I_NOP) begin e = V_DN; mk[i] = 0; end
      else if (op == I_HALT) begin mh[i] = 1; mhe[i] = 1; end
      return;
    end
    j = mk[i] - w - 2;
    mk[i] = 0;
    case (op)
      I_ADD:   e = V_WR | V_FR | V_OP1 | V_DN;
      I_SUB:   e = V_WR | V_FR | V_OP2 | V_DN;
      I_AND:   e = V_WR | V_FR | V_OP3 | V_DN;
      I_OR:    e = V_WR | V_FR | V_DN;
      I_MOVE:  e = V_WR | V_DN;
      I_LOAD:  begin
        e = V_AS;
        if (j == w) e = e | V_WR | V_CS | V_DN; else mk[i] = w + 3 + j;
      end
      I_STORE: begin
        e = V_AS;
        if (j == w) e = e | V_RW | V_DN; else mk[i] = w + 3 + j;
      end
      default: begin
        ov = ovs_of(i) ? sf[i] : uf[i];
        case (op)
          I_BRANCH: tk = 1;
          I_BZERO:  tk = zf[i];
          I_BNZERO: tk = !zf[i];
          I_BNEG:   tk = nf[i];
          I_BNNEG:  tk = !nf[i];
          I_BOV:    tk = ov;
          default:  tk = !ov;
        endcase
        e = tk ? (V_BR | V_PC | V_DN) : V_DN;
      end
    endcase
  endtask

  typedef struct {
    logic [3:0]  ins;
    logic        z, n, u, s;
    int          lat;
    logic [11:0] dv;
  } vec_t;

  vec_t        tbl [17];
  logic [11:0] q [$];
  logic [11:0] v, got, e;
  int          lat;

  initial begin
    // Instruction table for the MEM_WAIT=2, OV_SIGNED=0 instance.
    tbl[0]  = '{I_ADD,    0, 0, 0, 0, 5, V_WR | V_FR | V_OP1 | V_DN};
    tbl[1]  = '{I_SUB,    0, 0, 0, 0, 5, V_WR | V_FR | V_OP2 | V_DN};
    tbl[2]  = '{I_AND,    0, 0, 0, 0, 5, V_WR | V_FR | V_OP3 | V_DN};
    tbl[3]  = '{I_OR,     0, 0, 0, 0, 5, V_WR | V_FR | V_DN};
    tbl[4]  = '{I_MOVE,   0, 0, 0, 0, 5, V_WR | V_DN};
    tbl[5]  = '{I_LOAD,   0, 0, 0, 0, 7, V_AS | V_WR | V_CS | V_DN};
    tbl[6]  = '{I_STORE,  0, 0, 0, 0, 7, V_AS | V_RW | V_DN};
    tbl[7]  = '{I_NOP,    0, 0, 0, 0, 4, V_DN};
    tbl[8]  = '{I_BRANCH, 0, 0, 0, 0, 5, V_BR | V_PC | V_DN};
    tbl[9]  = '{I_BZERO,  1, 0, 0, 0, 5, V_BR | V_PC | V_DN};
    tbl[10] = '{I_BNZERO, 1, 0, 0, 0, 5, V_DN};
    tbl[11] = '{I_BNEG,   0, 1, 0, 0, 5, V_BR | V_PC | V_DN};
    tbl[12] = '{I_BNNEG,  0, 0, 0, 0, 5, V_BR | V_PC | V_DN};
    tbl[13] = '{I_BOV,    0, 0, 1, 0, 5, V_BR | V_PC | V_DN};
    tbl[14] = '{I_BNOV,   0, 0, 0, 1, 5, V_BR | V_PC | V_DN};
    tbl[15] = '{I_BOV,    0, 0, 0, 1, 5, V_DN};
    tbl[16] = '{I_HALT,   0, 0, 0, 0, 5, V_HT | V_DN};

    for (int i = 0; i < NI; i++) begin
      rst_n[i] = 1'b0;
      set_in(i, I_NOP, 0, 0, 0, 0);
    end
    nc(); nc();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("reset_zero_i%0d", i), int'(outs(i)), 0);
    end

    // ADD with no wait states.
    reset_inst(0, "add_rst");
    set_in(0, I_ADD, 0, 0, 0, 0);
    q = '{V_IR | V_PC, V_Z, V_WR | V_FR | V_OP1 | V_DN, V_IR | V_PC};
    run_seq(0, "add_w0", 0, q);

    // LOAD and STORE with two wait states.
    reset_inst(1, "ld_rst");
    set_in(1, I_LOAD, 0, 0, 0, 0);
    q = '{V_Z, V_Z, V_IR | V_PC, V_Z, V_AS, V_AS, V_AS | V_WR | V_CS | V_DN, V_Z};
    run_seq(1, "load_w2", 0, q);
    reset_inst(1, "st_rst");
    set_in(1, I_STORE, 0, 0, 0, 0);
    q = '{V_Z, V_Z, V_IR | V_PC, V_Z, V_AS, V_AS, V_AS | V_RW | V_DN, V_Z};
    run_seq(1, "store_w2", 0, q);

    // Conditional branches, back to back, and the overflow source selection.
    reset_inst(1, "bz_rst");
    set_in(1, I_BZERO, 0, 0, 0, 0);
    q = '{V_Z, V_Z, V_IR | V_PC, V_Z, V_DN};
    run_seq(1, "bzero_nt", 0, q);
    zf[1] = 1'b1;
    q = '{V_Z, V_Z, V_IR | V_PC, V_Z, V_BR | V_PC | V_DN};
    run_seq(1, "bzero_t", 1, q);
    set_in(1, I_BOV, 0, 0, 1, 0);
    run_seq(1, "bov_unsigned", 1, q);
    reset_inst(0, "bov_rst");
    set_in(0, I_BOV, 0, 0, 1, 0);
    q = '{V_IR | V_PC, V_Z, V_DN};
    run_seq(0, "bov_signed_nt", 0, q);

    // HALT with resume enabled.
    reset_inst(0, "h_rst");
    set_in(0, I_HALT, 0, 0, 0, 0);
    q = '{V_IR | V_PC, V_Z, V_HT | V_DN, V_HT, V_HT, V_HT, V_HT, V_HT};
    run_seq(0, "halt_res", 0, q);
    nc(); rs[0] = 1'b1; ck(0, "halt_res_req", V_HT);
    nc(); rs[0] = 1'b0; ck(0, "halt_res_fetch", V_IR | V_PC);

    // HALT is terminal when resume is disabled.
    reset_inst(1, "ht_rst");
    set_in(1, I_HALT, 0, 0, 0, 0);
    q = '{V_Z, V_Z, V_IR | V_PC, V_Z, V_HT | V_DN, V_HT, V_HT, V_HT, V_HT, V_HT};
    run_seq(1, "halt_term", 0, q);
    for (int k = 0; k < 3; k++) begin
      nc(); rs[1] = 1'b1; ck(1, "halt_term_resume", V_HT);
    end
    nc(); rs[1] = 1'b0; rst_n[1] = 1'b0; ck(1, "halt_term_rst", V_Z);

    // Reset during a STORE (MEM_WAIT=3) at wait count 1.
    reset_inst(2, "sr_rst");
    set_in(2, I_STORE, 0, 0, 0, 0);
    q = '{V_Z, V_Z, V_Z, V_IR | V_PC, V_Z, V_AS};
    run_seq(2, "st_pre", 0, q);
    nc(); rst_n[2] = 1'b0; ck(2, "st_midrst_a", V_Z);
    nc(); ck(2, "st_midrst_b", V_Z);
    nc(); rst_n[2] = 1'b1;
    q = '{V_Z, V_Z, V_Z, V_IR | V_PC, V_Z, V_AS, V_AS, V_AS, V_AS | V_RW | V_DN};
    run_seq(2, "st_post", 0, q);

    // Table-driven instruction latency / retire-cycle outputs.
    foreach (tbl[t]) begin
      reset_inst(1, "tbl_rst");
      set_in(1, tbl[t].ins, tbl[t].z, tbl[t].n, tbl[t].u, tbl[t].s);
      lat = 0;
      got = V_Z;
      for (int c = 1; c <= 20; c++) begin
        if (c > 1) nc();
        #3;
        v = outs(1);
        if (v[0]) begin
          lat = c;
          got = v;
          break;
        end
      end
      check($sformatf("tbl%0d_lat", t), lat, tbl[t].lat);
      check($sformatf("tbl%0d_retire", t), int'(got), int'(tbl[t].dv));
    end

    // Randomized run on all three instances against the reference model.
    for (int i = 0; i < NI; i++) begin
      mk[i] = 0; mh[i] = 0; mhe[i] = 0;
    end
    for (int cyc = 0; cyc < 3000 && failures < 20; cyc++) begin
      nc();
      for (int i = 0; i < NI; i++) begin
        rst_n[i] = (cyc != 0) && ($urandom_range(0, 99) != 0);
        if (mh[i] && !hr_of(i) && $urandom_range(0, 7) == 0) rst_n[i] = 1'b0;
        if (!mh[i] && mk[i] == 0) di[i] = 4'($urandom_range(0, 15));
        zf[i] = 1'($urandom_range(0, 1));
        nf[i] = 1'($urandom_range(0, 1));
        uf[i] = 1'($urandom_range(0, 1));
        sf[i] = 1'($urandom_range(0, 1));
        rs[i] = ($urandom_range(0, 3) == 0);
      end
      #3;
      for (int i = 0; i < NI; i++) begin
        model_step(i, e);
        check($sformatf("rnd_i%0d_c%0d", i, cyc), int'(outs(i)), int'(e));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
